fm_tx_sequencer: RTL and testbench

- Half-duplex push-to-talk sequencer and arbiter for the shared FM modulator.
- Two audio channels request transmit; the block grants one and drives the modulator's center-frequency and deviation words.
- Ramps a 12-bit amplitude gain up and down to avoid key clicks, then enforces a guard gap before the next grant.
- Sits between the audio handling path and the FM modulator, in the modulator clock domain.

---
 rtl/fm_tx_pkg.sv | 20 ++
 rtl/fm_tx_sequencer_if.sv | 30 +++
 rtl/fm_gain_ramp.sv | 58 +++++
 rtl/fm_tx_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fm_tx_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_tx_pkg.sv
// Shared definitions for the FM transmit sequencer: FSM state encoding,
// default carrier/deviation words and the default gain width.
package fm_tx_pkg;

   localparam int unsigned GAIN_WIDTH_DEF = 12;

   // Carrier words at a 500 MHz modulator clock: 48.5 MHz and 49.5 MHz
   localparam logic [31:0] CENTER_FRE_CH1_DEF = 32'd416611827;
   localparam logic [31:0] CENTER_FRE_CH2_DEF = 32'd425201762;
   localparam logic [31:0] MOVE_FRE_DEF       = 32'd105;

   typedef enum logic [2:0] {
      StIdle,
      StRampUp,
      StTx,
      StRampDown,
      StGuard
   } tx_state_e;

endpackage

// File: rtl/fm_tx_sequencer_if.sv
// Bundle between the audio path (requests) and the FM modulator controls.
// master: the sequencer side; slave: the requester / modulator side.
interface fm_tx_sequencer_if
   import fm_tx_pkg::*;
#(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned GAIN_WIDTH  = GAIN_WIDTH_DEF
) ();

   logic [1:0]             req;
   logic [1:0]             grant;
   logic                   sel_ch;
   logic [PHASE_WIDTH-1:0] center_fre;
   logic [PHASE_WIDTH-1:0] move_fre;
   logic [GAIN_WIDTH-1:0]  gain;
   logic                   mod_en;
   logic                   tx_active;
   logic                   timeout_flag;

   modport master (
      input  req,
      output grant, sel_ch, center_fre, move_fre, gain, mod_en, tx_active, timeout_flag
   );

   modport slave (
      output req,
      input  grant, sel_ch, center_fre, move_fre, gain, mod_en, tx_active, timeout_flag
   );

endinterface

// File: rtl/fm_gain_ramp.sv
// Saturating up/down gain accumulator. at_max_o / at_zero_o tell whether a
// step taken this clock lands on full scale / zero, so the caller can change
// state on the same edge the gain arrives there.
module fm_gain_ramp
   import fm_tx_pkg::*;
#(
   parameter int unsigned GAIN_WIDTH = GAIN_WIDTH_DEF,
   parameter int unsigned RAMP_STEP  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  up_i,
   input  logic                  down_i,
   output logic [GAIN_WIDTH-1:0] gain_o,
   output logic                  mod_en_o,
   output logic                  at_max_o,
   output logic                  at_zero_o
);

   localparam int unsigned FullInt = (2 ** GAIN_WIDTH) - 1;
   localparam int unsigned StepSat = (RAMP_STEP > FullInt) ? FullInt : RAMP_STEP;
   localparam logic [GAIN_WIDTH:0] FullScale = (GAIN_WIDTH + 1)'(FullInt);
   localparam logic [GAIN_WIDTH:0] StepW     = (GAIN_WIDTH + 1)'(StepSat);

   logic [GAIN_WIDTH-1:0] gain_q, gain_d, inc_val, dec_val;
   logic [GAIN_WIDTH:0]   sum;
   logic                  mod_en_q;

   // Saturating step candidates and the selected next gain
   always_comb begin
      sum     = {1'b0, gain_q} + StepW;
      inc_val = (sum >= FullScale) ? FullScale[GAIN_WIDTH-1:0] : sum[GAIN_WIDTH-1:0];
      dec_val = ({1'b0, gain_q} > StepW) ? (gain_q - StepW[GAIN_WIDTH-1:0]) : '0;
      gain_d  = gain_q;
      if (up_i) begin
         gain_d = inc_val;
      end else if (down_i) begin
         gain_d = dec_val;
      end
   end

   // Gain register; mod_en registered alongside so both change together
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gain_q   <= '0;
         mod_en_q <= 1'b0;
      end else begin
         gain_q   <= gain_d;
         mod_en_q <= (gain_d != '0);
      end
   end

   assign gain_o    = gain_q;
   assign mod_en_o  = mod_en_q;
   assign at_max_o  = ({1'b0, inc_val} == FullScale);
   assign at_zero_o = (dec_val == '0);

endmodule

// File: rtl/fm_tx_sequencer.sv
// Push-to-talk sequencer/arbiter for the shared FM modulator.
// IDLE -> RAMP_UP -> TX -> RAMP_DOWN -> GUARD -> IDLE, round-robin on ties.
// Optional transmit timeout enabled by defining FM_TX_SEQ_TIMEOUT_EN.
module fm_tx_sequencer
   import fm_tx_pkg::*;
#(
   parameter int unsigned            PHASE_WIDTH    = 32,
   parameter int unsigned            GAIN_WIDTH     = GAIN_WIDTH_DEF,
   parameter int unsigned            RAMP_STEP      = 16,
   parameter int unsigned            GUARD_CYCLES   = 1000,
   parameter int unsigned            MAX_TX_CYCLES  = 50000000,
   parameter logic [PHASE_WIDTH-1:0] CENTER_FRE_CH1 = PHASE_WIDTH'(CENTER_FRE_CH1_DEF),
   parameter logic [PHASE_WIDTH-1:0] CENTER_FRE_CH2 = PHASE_WIDTH'(CENTER_FRE_CH2_DEF),
   parameter logic [PHASE_WIDTH-1:0] MOVE_FRE       = PHASE_WIDTH'(MOVE_FRE_DEF)
) (
   input logic                clk_in,
   input logic                RST,
   fm_tx_sequencer_if.master  bus_io
);

   // GUARD_CYCLES = 0 still spends one clock in GUARD
   localparam logic [31:0] GuardLast = (GUARD_CYCLES > 0) ? 32'(GUARD_CYCLES - 1) : 32'd0;

   tx_state_e              state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic                   sel_q, sel_d;
   logic [PHASE_WIDTH-1:0] center_q, center_d;
   logic [PHASE_WIDTH-1:0] move_q, move_d;
   logic                   tx_active_q, tx_active_d;
   logic                   last_q, last_d;
   logic [31:0]            guard_cnt_q, guard_cnt_d;

   logic [1:0] req;
   logic [1:0] blocked;
   logic [1:0] eligible;
   logic       granted_req;
   logic       pick;
   logic       timeout_hit;
   logic       ramp_up, ramp_down;
   logic       at_max, at_zero;

   assign req         = bus_io.req;
   assign eligible    = req & ~blocked;
   assign granted_req = sel_q ? req[1] : req[0];

   fm_gain_ramp #(
      .GAIN_WIDTH (GAIN_WIDTH),
      .RAMP_STEP  (RAMP_STEP)
   ) u_gain_ramp (
      .clk_i     (clk_in),
      .rst_i     (RST),
      .up_i      (ramp_up),
      .down_i    (ramp_down),
      .gain_o    (bus_io.gain),
      .mod_en_o  (bus_io.mod_en),
      .at_max_o  (at_max),
      .at_zero_o (at_zero)
   );

   // Next-state, arbitration and registered-output updates
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      center_d    = center_q;
      move_d      = move_q;
      last_d      = last_q;
      guard_cnt_d = guard_cnt_q;
      ramp_up     = 1'b0;
      ramp_down   = 1'b0;
      pick        = (eligible == 2'b11) ? ~last_q : eligible[1];

      unique case (state_q)
         StIdle: begin
            guard_cnt_d = '0;
            if (eligible != 2'b00) begin
               state_d  = StRampUp;
               grant_d  = pick ? 2'b10 : 2'b01;
               sel_d    = pick;
               center_d = pick ? CENTER_FRE_CH2 : CENTER_FRE_CH1;
               move_d   = MOVE_FRE;
               last_d   = pick;
            end
         end
         StRampUp: begin
            // A release mid-ramp holds the current gain and ramps down from it
            if (!granted_req || timeout_hit) begin
               state_d = StRampDown;
            end else begin
               ramp_up = 1'b1;
               if (at_max) begin
                  state_d = StTx;
               end
            end
         end
         StTx: begin
            if (!granted_req || timeout_hit) begin
               state_d = StRampDown;
            end
         end
         StRampDown: begin
            ramp_down = 1'b1;
            if (at_zero) begin
               state_d     = StGuard;
               grant_d     = 2'b00;
               move_d      = '0;
               guard_cnt_d = '0;
            end
         end
         StGuard: begin
            if (guard_cnt_q >= GuardLast) begin
               state_d = StIdle;
            end else begin
               guard_cnt_d = guard_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      tx_active_d = (state_d == StRampUp) || (state_d == StTx);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk_in or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         grant_q     <= 2'b00;
         sel_q       <= 1'b0;
         center_q    <= CENTER_FRE_CH1;
         move_q      <= '0;
         tx_active_q <= 1'b0;
         last_q      <= 1'b1;
         guard_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         center_q    <= center_d;
         move_q      <= move_d;
         tx_active_q <= tx_active_d;
         last_q      <= last_d;
         guard_cnt_q <= guard_cnt_d;
      end
   end

   assign bus_io.grant      = grant_q;
   assign bus_io.sel_ch     = sel_q;
   assign bus_io.center_fre = center_q;
   assign bus_io.move_fre   = move_q;
   assign bus_io.tx_active  = tx_active_q;

`ifdef FM_TX_SEQ_TIMEOUT_EN
   localparam logic [31:0] TxLast = (MAX_TX_CYCLES > 0) ? 32'(MAX_TX_CYCLES - 1) : 32'd0;

   logic [31:0] tx_cnt_q, tx_cnt_d;
   logic [1:0]  to_ch_q, to_ch_d;
   logic        flag_q;

   assign timeout_hit = ((state_q == StRampUp) || (state_q == StTx)) && (tx_cnt_q >= TxLast);
   assign blocked     = to_ch_q;

   // Transmit-time counter and per-channel lockout after a timeout
   always_comb begin
      tx_cnt_d = tx_cnt_q;
      to_ch_d  = to_ch_q;
      if (state_q == StIdle) begin
         tx_cnt_d = '0;
         to_ch_d  = to_ch_q & req;
      end else if ((state_q == StRampUp) || (state_q == StTx)) begin
         tx_cnt_d = tx_cnt_q + 32'd1;
      end
      if (timeout_hit) begin
         to_ch_d = to_ch_q | (sel_q ? 2'b10 : 2'b01);
      end
   end

   // Timeout state registers
   always_ff @(posedge clk_in or posedge RST) begin
      if (RST) begin
         tx_cnt_q <= '0;
         to_ch_q  <= 2'b00;
         flag_q   <= 1'b0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         to_ch_q  <= to_ch_d;
         flag_q   <= (to_ch_d != 2'b00);
      end
   end

   assign bus_io.timeout_flag = flag_q;
`else
   logic unused_max_tx;

   assign timeout_hit         = 1'b0;
   assign blocked             = 2'b00;
   assign bus_io.timeout_flag = 1'b0;
   assign unused_max_tx       = ^MAX_TX_CYCLES;
`endif

endmodule

// File: tb/tb_fm_tx_sequencer.sv
// Directed bench for fm_tx_sequencer: vector table for the basic ramp/guard
// cycle, hand sequences for arbitration, early release, reset and timeout.
module tb_fm_tx_sequencer;

   localparam logic [31:0] C1 = 32'd416611827;
   localparam logic [31:0] C2 = 32'd425201762;
   localparam logic [31:0] MV = 32'd105;

   logic clk_in;
   logic RST;

   int n_cmp  = 0;
   int n_fail = 0;

   fm_tx_sequencer_if #(.PHASE_WIDTH(32), .GAIN_WIDTH(12)) bus_a ();
   fm_tx_sequencer_if #(.PHASE_WIDTH(32), .GAIN_WIDTH(12)) bus_b ();

   fm_tx_sequencer #(
      .PHASE_WIDTH   (32),
      .GAIN_WIDTH    (12),
      .RAMP_STEP     (1024),
      .GUARD_CYCLES  (8),
      .MAX_TX_CYCLES (20)
   ) dut_a (
      .clk_in (clk_in),
      .RST    (RST),
      .bus_io (bus_a)
   );

   fm_tx_sequencer #(
      .PHASE_WIDTH   (32),
      .GAIN_WIDTH    (12),
      .RAMP_STEP     (1024),
      .GUARD_CYCLES  (0),
      .MAX_TX_CYCLES (20)
   ) dut_b (
      .clk_in (clk_in),
      .RST    (RST),
      .bus_io (bus_b)
   );

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  grant;
      logic [11:0] gain;
      logic [31:0] move;
      logic        sel;
      logic [31:0] center;
      logic        mod_en;
      logic        tx_active;
   } vec_t;

   vec_t vecs[$];

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      bus_a.req = 2'b00;
      bus_b.req = 2'b00;
      #3;
      RST = 1'b0;
   endtask

   // Step until grant equals want; an expired bound is a failed comparison
   task automatic wait_grant(input logic [1:0] want, input int maxc, output int cyc);
      cyc = 0;
      while (bus_a.grant !== want && cyc < maxc) begin
         step();
         cyc++;
      end
      check("wait_grant", bus_a.grant, want);
   endtask

   int n;

   initial begin
      RST       = 1'b1;
      bus_a.req = 2'b00;
      bus_b.req = 2'b00;

      // Reset values, held across a clock edge
      @(posedge clk_in);
      #1;
      check("rst grant",     bus_a.grant, 2'b00);
      check("rst sel",       bus_a.sel_ch, 1'b0);
      check("rst center",    bus_a.center_fre, C1);
      check("rst move",      bus_a.move_fre, 0);
      check("rst gain",      bus_a.gain, 0);
      check("rst mod_en",    bus_a.mod_en, 1'b0);
      check("rst tx_active", bus_a.tx_active, 1'b0);
      check("rst timeout",   bus_a.timeout_flag, 1'b0);
      #2;
      RST = 1'b0;

      // Fields: req, grant, gain, move, sel, center, mod_en, tx_active
      vecs.push_back('{2'b01, 2'b01,    0, MV, 1'b0, C1, 1'b0, 1'b1});
      vecs.push_back('{2'b01, 2'b01, 1024, MV, 1'b0, C1, 1'b1, 1'b1});
      vecs.push_back('{2'b01, 2'b01, 2048, MV, 1'b0, C1, 1'b1, 1'b1});
      vecs.push_back('{2'b01, 2'b01, 3072, MV, 1'b0, C1, 1'b1, 1'b1});
      vecs.push_back('{2'b01, 2'b01, 4095, MV, 1'b0, C1, 1'b1, 1'b1});
      vecs.push_back('{2'b01, 2'b01, 4095, MV, 1'b0, C1, 1'b1, 1'b1});
      vecs.push_back('{2'b00, 2'b01, 4095, MV, 1'b0, C1, 1'b1, 1'b0});
      vecs.push_back('{2'b00, 2'b01, 3071, MV, 1'b0, C1, 1'b1, 1'b0});
      vecs.push_back('{2'b00, 2'b01, 2047, MV, 1'b0, C1, 1'b1, 1'b0});
      vecs.push_back('{2'b00, 2'b01, 1023, MV, 1'b0, C1, 1'b1, 1'b0});
      vecs.push_back('{2'b00, 2'b00,    0,  0, 1'b0, C1, 1'b0, 1'b0});
      // Request held through GUARD: not granted until after the 8th guard clock
      for (int i = 0; i < 8; i++) begin
         vecs.push_back('{2'b01, 2'b00, 0, 0, 1'b0, C1, 1'b0, 1'b0});
      end
      vecs.push_back('{2'b01, 2'b01, 0, MV, 1'b0, C1, 1'b0, 1'b1});

      for (int i = 0; i < vecs.size(); i++) begin
         bus_a.req = vecs[i].req;
         step();
         check($sformatf("v%0d grant", i),  bus_a.grant, vecs[i].grant);
         check($sformatf("v%0d gain", i),   bus_a.gain, vecs[i].gain);
         check($sformatf("v%0d move", i),   bus_a.move_fre, vecs[i].move);
         check($sformatf("v%0d sel", i),    bus_a.sel_ch, vecs[i].sel);
         check($sformatf("v%0d center", i), bus_a.center_fre, vecs[i].center);
         check($sformatf("v%0d mod_en", i), bus_a.mod_en, vecs[i].mod_en);
         check($sformatf("v%0d tx_act", i), bus_a.tx_active, vecs[i].tx_active);
      end

      // Tie from reset: CH1 first, then CH2 on the next tie
      do_reset();
      bus_a.req = 2'b11;
      step();
      check("tie1 grant", bus_a.grant, 2'b01);
      check("tie1 sel",   bus_a.sel_ch, 1'b0);
      bus_a.req = 2'b10;
      wait_grant(2'b00, 20, n);
      check("tie1 cycles to guard", n, 2);
      bus_a.req = 2'b11;
      wait_grant(2'b10, 20, n);
      check("tie2 guard latency", n, 9);
      check("tie2 sel",    bus_a.sel_ch, 1'b1);
      check("tie2 center", bus_a.center_fre, C2);
      check("tie2 move",   bus_a.move_fre, MV);

      // Early release at gain 2048: ramps down without reaching TX
      do_reset();
      bus_a.req = 2'b01;
      step();
      step();
      step();
      check("early gain 2048", bus_a.gain, 2048);
      bus_a.req = 2'b00;
      step();
      check("early hold gain", bus_a.gain, 2048);
      check("early tx_active", bus_a.tx_active, 1'b0);
      step();
      check("early gain 1024", bus_a.gain, 1024);
      step();
      check("early gain 0",    bus_a.gain, 0);
      check("early grant 0",   bus_a.grant, 2'b00);
      check("early center",    bus_a.center_fre, C1);
      bus_a.req = 2'b10;
      wait_grant(2'b10, 20, n);
      check("early guard wait", n, 9);
      check("early ch2 center", bus_a.center_fre, C2);

      // Asynchronous reset mid-ramp
      do_reset();
      bus_a.req = 2'b01;
      step();
      step();
      step();
      step();
      check("rst-mid gain 3072", bus_a.gain, 3072);
      #2;
      RST = 1'b1;
      #1;
      check("rst-mid gain",   bus_a.gain, 0);
      check("rst-mid grant",  bus_a.grant, 2'b00);
      check("rst-mid move",   bus_a.move_fre, 0);
      check("rst-mid mod_en", bus_a.mod_en, 1'b0);
      #1;
      RST = 1'b0;
      step();
      check("rst-mid regrant", bus_a.grant, 2'b01);

      // GUARD_CYCLES = 0: exactly one guard clock
      do_reset();
      bus_b.req = 2'b01;
      step();
      check("g0 grant", bus_b.grant, 2'b01);
      bus_b.req = 2'b00;
      step();
      step();
      check("g0 guard grant", bus_b.grant, 2'b00);
      bus_b.req = 2'b01;
      step();
      check("g0 still guard", bus_b.grant, 2'b00);
      step();
      check("g0 regrant", bus_b.grant, 2'b01);

`ifdef FM_TX_SEQ_TIMEOUT_EN
      // Timeout after 20 clocks in RAMP_UP/TX locks CH1 out
      do_reset();
      bus_a.req = 2'b01;
      step();
      repeat (19) step();
      check("to flag before", bus_a.timeout_flag, 1'b0);
      step();
      check("to flag set",  bus_a.timeout_flag, 1'b1);
      check("to tx_active", bus_a.tx_active, 1'b0);
      check("to gain held", bus_a.gain, 4095);
      wait_grant(2'b00, 20, n);
      check("to ramp down", n, 4);
      repeat (12) step();
      check("to ch1 locked", bus_a.grant, 2'b00);
      check("to flag held",  bus_a.timeout_flag, 1'b1);
      bus_a.req = 2'b11;
      step();
      check("to ch2 granted", bus_a.grant, 2'b10);
      bus_a.req = 2'b00;
      wait_grant(2'b00, 20, n);
      repeat (8) step();
      check("to flag in guard", bus_a.timeout_flag, 1'b1);
      step();
      check("to flag cleared", bus_a.timeout_flag, 1'b0);
`else
      check("no-to flag", bus_a.timeout_flag, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
